// File: rtl/regfile_port_arbiter.sv
// Arbiter sharing a single-port register file between one commit-stage writer
// and NUM_RD readers; read data returns to the granted reader one cycle later.
module regfile_port_arbiter #(
    parameter int NUM_RD          = 3,
    parameter int WR_STARVE_LIMIT = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [NUM_RD-1:0]     rd_req_valid,
    input  logic [5*NUM_RD-1:0]   rd_req_id,
    output logic [NUM_RD-1:0]     rd_req_ready,
    output logic [NUM_RD-1:0]     rd_rsp_valid,
    output logic [31:0]           rd_rsp_data,
    input  logic                  wr_req_valid,
    input  logic [4:0]            wr_req_id,
    input  logic [31:0]           wr_req_data,
    output logic                  wr_req_ready,
    output logic                  rf_have_task,
    output logic [4:0]            rf_reg_id,
    output logic                  rf_rw,
    output logic [31:0]           rf_data_in,
    input  logic [31:0]           rf_data_out
);

    localparam int PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int CNT_W = $clog2(WR_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(WR_STARVE_LIMIT);
    localparam logic [PTR_W:0]   NUM_RD_W   = (PTR_W + 1)'(NUM_RD);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_RD - 1);

    logic [PTR_W-1:0] rr_ptr_r;
    logic [CNT_W-1:0] starve_cnt_r;
    logic             rsp_pend_r;
    logic [PTR_W-1:0] rsp_sel_r;

    logic [4:0]       rd_id_s [NUM_RD];
    logic             any_rd_s;
    logic             rd_found_s;
    logic [PTR_W-1:0] rd_idx_s;
    logic             grant_en_s;
    logic             starve_hit_s;
    logic             wr_grant_s;
    logic             rd_grant_s;
    logic [PTR_W-1:0] rr_next_s;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_unpack_id
        assign rd_id_s[g] = rd_req_id[5*g +: 5];
    end

    // Round-robin search: first valid reader at or after rr_ptr, wrapping.
    always_comb begin
        logic [PTR_W:0] sum_v;
        logic [PTR_W-1:0] idx_v;
        sum_v      = '0;
        idx_v      = '0;
        rd_found_s = 1'b0;
        rd_idx_s   = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            sum_v      = {1'b0, rr_ptr_r} + (PTR_W + 1)'(k);
            sum_v      = (sum_v >= NUM_RD_W) ? (sum_v - NUM_RD_W) : sum_v;
            idx_v      = sum_v[PTR_W-1:0];
            rd_idx_s   = (!rd_found_s && rd_req_valid[idx_v]) ? idx_v : rd_idx_s;
            rd_found_s = rd_found_s | rd_req_valid[idx_v];
        end
    end

    // Grant decision: write wins unless a waiting read has been starved long enough.
    always_comb begin
        any_rd_s     = |rd_req_valid;
        grant_en_s   = rdy_in & (~rsp_pend_r | rdy_in);
        starve_hit_s = any_rd_s & (starve_cnt_r == STARVE_MAX);
        wr_grant_s   = grant_en_s & wr_req_valid & ~starve_hit_s;
        rd_grant_s   = grant_en_s & ~wr_grant_s & rd_found_s;
        rr_next_s    = (rd_idx_s == LAST_IDX) ? '0 : (rd_idx_s + PTR_W'(1));
        wr_req_ready = wr_grant_s;
        rd_req_ready = rd_grant_s ? (NUM_RD'(1'b1) << rd_idx_s) : '0;
    end

    // Register-file command; an x0 write retires without touching the file.
    always_comb begin
        rf_have_task = 1'b0;
        rf_reg_id    = 5'd0;
        rf_rw        = 1'b0;
        rf_data_in   = 32'd0;
        if (wr_grant_s && (wr_req_id != 5'd0)) begin
            rf_have_task = 1'b1;
            rf_reg_id    = wr_req_id;
            rf_rw        = 1'b1;
            rf_data_in   = wr_req_data;
        end else if (rd_grant_s) begin
            rf_have_task = 1'b1;
            rf_reg_id    = rd_id_s[rd_idx_s];
        end else begin
            rf_have_task = 1'b0;
        end
    end

    // Response strobe and data, qualified by the pending-response register.
    always_comb begin
        rd_rsp_valid = rsp_pend_r ? (NUM_RD'(1'b1) << rsp_sel_r) : '0;
        rd_rsp_data  = rsp_pend_r ? rf_data_out : 32'd0;
    end

    // Pending-response tracking; held while rdy_in is low so the strobe is not lost.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rsp_pend_r <= 1'b0;
            rsp_sel_r  <= '0;
        end else if (rd_grant_s) begin
            rsp_pend_r <= 1'b1;
            rsp_sel_r  <= rd_idx_s;
        end else if (rdy_in) begin
            rsp_pend_r <= 1'b0;
        end else begin
            rsp_pend_r <= rsp_pend_r;
        end
    end

    // Round-robin pointer advances past the reader just served.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr_r <= '0;
        end else if (rd_grant_s) begin
            rr_ptr_r <= rr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Consecutive write grants while a read waits, saturating at the limit.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            starve_cnt_r <= '0;
        end else if (rd_grant_s || !any_rd_s) begin
            starve_cnt_r <= '0;
        end else if (wr_grant_s && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a small synchronous register-file model.
module tb_regfile_port_arbiter;

    localparam int NUM_RD = 3;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic [NUM_RD-1:0] rd_req_valid;
    logic [14:0]       rd_req_id;
    logic [NUM_RD-1:0] rd_req_ready;
    logic [NUM_RD-1:0] rd_rsp_valid;
    logic [31:0]       rd_rsp_data;
    logic              wr_req_valid;
    logic [4:0]        wr_req_id;
    logic [31:0]       wr_req_data;
    logic              wr_req_ready;
    logic              rf_have_task;
    logic [4:0]        rf_reg_id;
    logic              rf_rw;
    logic [31:0]       rf_data_in;
    logic [31:0]       rf_data_out = 32'd0;

    logic [31:0]       rf_mem [32];
    logic              rf_init_done = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    regfile_port_arbiter #(.NUM_RD(NUM_RD), .WR_STARVE_LIMIT(4)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rd_req_valid (rd_req_valid),
        .rd_req_id    (rd_req_id),
        .rd_req_ready (rd_req_ready),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .wr_req_valid (wr_req_valid),
        .wr_req_id    (wr_req_id),
        .wr_req_data  (wr_req_data),
        .wr_req_ready (wr_req_ready),
        .rf_have_task (rf_have_task),
        .rf_reg_id    (rf_reg_id),
        .rf_rw        (rf_rw),
        .rf_data_in   (rf_data_in),
        .rf_data_out  (rf_data_out)
    );

    // Register file: preloaded contents, synchronous write and registered read, x0 fixed at 0.
    always @(posedge clk_in) begin
        if (!rf_init_done) begin
            for (int i = 0; i < 32; i++) begin
                rf_mem[i] <= 32'd0;
            end
            rf_mem[1]    <= 32'h1111_1111;
            rf_mem[2]    <= 32'h2222_2222;
            rf_mem[3]    <= 32'h3333_3333;
            rf_mem[5]    <= 32'hDEAD_BEEF;
            rf_init_done <= 1'b1;
        end else if (rf_have_task) begin
            if (rf_rw) begin
                if (rf_reg_id != 5'd0) rf_mem[rf_reg_id] <= rf_data_in;
            end else begin
                rf_data_out <= rf_mem[rf_reg_id];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    logic [2:0]  rr_grant [4];
    logic [31:0] rr_data  [4];

    initial begin
        rr_grant[0] = 3'b001; rr_grant[1] = 3'b010; rr_grant[2] = 3'b100; rr_grant[3] = 3'b001;
        rr_data[0]  = 32'h1111_1111; rr_data[1] = 32'h2222_2222;
        rr_data[2]  = 32'h3333_3333; rr_data[3] = 32'h1111_1111;

        rst_in = 1'b0; rdy_in = 1'b0;
        rd_req_valid = 3'b000; rd_req_id = 15'd0;
        wr_req_valid = 1'b0; wr_req_id = 5'd0; wr_req_data = 32'd0;
        #2;
        check_eq("rst_rd_ready", 32'(rd_req_ready), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_req_ready), 32'd0);
        check_eq("rst_have_task", 32'(rf_have_task), 32'd0);
        check_eq("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
        tick();
        tick();
        rst_in = 1'b1; rdy_in = 1'b1;

        // Single read of x5 by reader 0
        rd_req_id = {5'd0, 5'd0, 5'd5}; rd_req_valid = 3'b001;
        #2;
        check_eq("sr_grant", 32'(rd_req_ready), 32'(3'b001));
        check_eq("sr_have_task", 32'(rf_have_task), 32'd1);
        check_eq("sr_rw", 32'(rf_rw), 32'd0);
        check_eq("sr_reg_id", 32'(rf_reg_id), 32'd5);
        check_eq("sr_data_in", rf_data_in, 32'd0);
        tick();
        rd_req_valid = 3'b000;
        #2;
        check_eq("sr_rsp_valid", 32'(rd_rsp_valid), 32'(3'b001));
        check_eq("sr_rsp_data", rd_rsp_data, 32'hDEAD_BEEF);
        check_eq("sr_idle_have", 32'(rf_have_task), 32'd0);
        check_eq("sr_idle_reg", 32'(rf_reg_id), 32'd0);
        tick();
        #2;
        check_eq("sr_rsp_done", 32'(rd_rsp_valid), 32'd0);

        // Write priority, then read-after-write of x7 (rr_ptr = 1)
        wr_req_valid = 1'b1; wr_req_id = 5'd7; wr_req_data = 32'h1234_5678;
        rd_req_id = {5'd7, 5'd7, 5'd7}; rd_req_valid = 3'b111;
        #2;
        check_eq("wp_wr_ready", 32'(wr_req_ready), 32'd1);
        check_eq("wp_rd_ready", 32'(rd_req_ready), 32'd0);
        check_eq("wp_rw", 32'(rf_rw), 32'd1);
        check_eq("wp_reg_id", 32'(rf_reg_id), 32'd7);
        check_eq("wp_data_in", rf_data_in, 32'h1234_5678);
        tick();
        wr_req_valid = 1'b0;
        #2;
        check_eq("wp_rd_grant1", 32'(rd_req_ready), 32'(3'b010));
        check_eq("wp_rd_rw", 32'(rf_rw), 32'd0);
        tick();
        rd_req_valid = 3'b101;
        #2;
        check_eq("wp_rsp1_valid", 32'(rd_rsp_valid), 32'(3'b010));
        check_eq("wp_rsp1_data", rd_rsp_data, 32'h1234_5678);
        check_eq("wp_rd_grant2", 32'(rd_req_ready), 32'(3'b100));
        tick();
        rd_req_valid = 3'b000;
        #2;
        check_eq("wp_rsp2_valid", 32'(rd_rsp_valid), 32'(3'b100));
        check_eq("wp_rsp2_data", rd_rsp_data, 32'h1234_5678);
        tick();

        // Round-robin with all readers held valid (rr_ptr = 0)
        rd_req_id = {5'd3, 5'd2, 5'd1}; rd_req_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #2;
            check_eq($sformatf("rr_grant%0d", c), 32'(rd_req_ready), 32'(rr_grant[c]));
            if (c > 0) begin
                check_eq($sformatf("rr_rsp_valid%0d", c), 32'(rd_rsp_valid), 32'(rr_grant[c-1]));
                check_eq($sformatf("rr_rsp_data%0d", c), rd_rsp_data, rr_data[c-1]);
            end else begin
                check_eq("rr_rsp_valid0", 32'(rd_rsp_valid), 32'd0);
            end
            tick();
        end
        rd_req_valid = 3'b000;
        #2;
        check_eq("rr_rsp_valid4", 32'(rd_rsp_valid), 32'(rr_grant[3]));
        check_eq("rr_rsp_data4", rd_rsp_data, rr_data[3]);
        tick();

        // Starvation guard: writes held for 10 cycles, reader 1 waiting
        wr_req_valid = 1'b1; wr_req_id = 5'd9; wr_req_data = 32'hA5A5_A5A5;
        rd_req_id = {5'd0, 5'd2, 5'd0}; rd_req_valid = 3'b010;
        for (int c = 0; c < 10; c++) begin
            #2;
            check_eq($sformatf("sg_wr%0d", c), 32'(wr_req_ready), (c == 4) ? 32'd0 : 32'd1);
            check_eq($sformatf("sg_rd%0d", c), 32'(rd_req_ready), (c == 4) ? 32'(3'b010) : 32'd0);
            if (c == 5) begin
                check_eq("sg_rsp_valid", 32'(rd_rsp_valid), 32'(3'b010));
                check_eq("sg_rsp_data", rd_rsp_data, 32'h2222_2222);
            end
            tick();
            if (c == 4) rd_req_valid = 3'b000;
        end
        wr_req_valid = 1'b0;

        // Write to x0 retires without a register-file task (rr_ptr = 2)
        wr_req_valid = 1'b1; wr_req_id = 5'd0; wr_req_data = 32'hFFFF_FFFF;
        #2;
        check_eq("x0_wr_ready", 32'(wr_req_ready), 32'd1);
        check_eq("x0_have_task", 32'(rf_have_task), 32'd0);
        check_eq("x0_rw", 32'(rf_rw), 32'd0);
        check_eq("x0_data_in", rf_data_in, 32'd0);
        tick();
        wr_req_valid = 1'b0;
        rd_req_id = {5'd0, 5'd0, 5'd0}; rd_req_valid = 3'b100;
        #2;
        check_eq("x0_rd_grant", 32'(rd_req_ready), 32'(3'b100));
        check_eq("x0_rd_have", 32'(rf_have_task), 32'd1);
        tick();
        rd_req_valid = 3'b000;
        #2;
        check_eq("x0_rsp_valid", 32'(rd_rsp_valid), 32'(3'b100));
        check_eq("x0_rsp_data", rd_rsp_data, 32'd0);
        tick();

        // Pause: response held through 3 cycles of rdy_in low (rr_ptr = 0)
        rd_req_id = {5'd0, 5'd0, 5'd5}; rd_req_valid = 3'b001;
        #2;
        check_eq("pz_grant", 32'(rd_req_ready), 32'(3'b001));
        tick();
        rdy_in = 1'b0;
        rd_req_id = {5'd0, 5'd1, 5'd0}; rd_req_valid = 3'b010;
        wr_req_valid = 1'b1; wr_req_id = 5'd3; wr_req_data = 32'd0;
        for (int c = 0; c < 3; c++) begin
            #2;
            check_eq($sformatf("pz_rsp_valid%0d", c), 32'(rd_rsp_valid), 32'(3'b001));
            check_eq($sformatf("pz_rsp_data%0d", c), rd_rsp_data, 32'hDEAD_BEEF);
            check_eq($sformatf("pz_rd_ready%0d", c), 32'(rd_req_ready), 32'd0);
            check_eq($sformatf("pz_wr_ready%0d", c), 32'(wr_req_ready), 32'd0);
            check_eq($sformatf("pz_have%0d", c), 32'(rf_have_task), 32'd0);
            tick();
        end
        rdy_in = 1'b1; rd_req_valid = 3'b000; wr_req_valid = 1'b0;
        #2;
        check_eq("pz_rsp_recover", 32'(rd_rsp_valid), 32'(3'b001));
        check_eq("pz_data_recover", rd_rsp_data, 32'hDEAD_BEEF);
        tick();
        #2;
        check_eq("pz_rsp_consumed", 32'(rd_rsp_valid), 32'd0);

        // Reset during a response cycle (rr_ptr = 1)
        rd_req_id = {5'd0, 5'd2, 5'd0}; rd_req_valid = 3'b010;
        #2;
        check_eq("rm_grant", 32'(rd_req_ready), 32'(3'b010));
        tick();
        rd_req_valid = 3'b000;
        #2;
        check_eq("rm_rsp_valid", 32'(rd_rsp_valid), 32'(3'b010));
        rst_in = 1'b0;
        #1;
        check_eq("rm_rsp_cleared", 32'(rd_rsp_valid), 32'd0);
        check_eq("rm_data_cleared", rd_rsp_data, 32'd0);
        check_eq("rm_have_task", 32'(rf_have_task), 32'd0);
        check_eq("rm_rd_ready", 32'(rd_req_ready), 32'd0);
        tick();
        tick();
        rst_in = 1'b1;
        #2;
        check_eq("rm_no_strobe", 32'(rd_rsp_valid), 32'd0);
        rd_req_id = {5'd3, 5'd2, 5'd1}; rd_req_valid = 3'b111;
        #2;
        check_eq("rm_ptr_reset", 32'(rd_req_ready), 32'(3'b001));
        tick();
        rd_req_valid = 3'b000;
        #2;
        check_eq("rm_rsp_after", 32'(rd_rsp_valid), 32'(3'b001));
        check_eq("rm_data_after", rd_rsp_data, 32'h1111_1111);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
